// File: rtl/axi_tile_unpacker.sv
// axi_tile_unpacker
//
// Unpacks a burst of AXI read-data beats into SRAM_A/B/C bank write requests.
// The block owns the beat counter: each accepted beat k is written to bank row
// (k % PE_N), page (k / PE_N). A/B beats pass through verbatim; C beats are
// split into PE_N elements and widened to one bank cell each (FP32 passes,
// FP16 zero-extends, INT8/INT4 sign-extend).
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   start, cfg_mat, cfg_type, cfg_len
//                            transaction programming, latched on start in IDLE
//   busy, done, err          status: not idle, 1-cycle end pulse, sticky error
//   s_valid/s_ready/s_data/s_last
//                            AXI R beat stream (slave side)
//   wr_valid/wr_ready/wr_mat/wr_row/wr_page/wr_cell_en/wr_data
//                            bank write request, registered, held under stall
`timescale 1ns/1ps

module axi_tile_unpacker #(
    parameter  int BUS_W     = 256,
    parameter  int PE_N      = 8,
    parameter  int CELL_W    = 32,
    parameter  int MAX_BEATS = 64,
    localparam int LEN_W     = $clog2(MAX_BEATS) + 1,
    localparam int PG_W      = (MAX_BEATS / PE_N > 1) ? $clog2(MAX_BEATS / PE_N) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [1:0]               cfg_mat,
    input  logic [1:0]               cfg_type,
    input  logic [LEN_W-1:0]         cfg_len,
    output logic                     busy,
    output logic                     done,
    output logic                     err,
    input  logic                     s_valid,
    output logic                     s_ready,
    input  logic [BUS_W-1:0]         s_data,
    input  logic                     s_last,
    output logic                     wr_valid,
    input  logic                     wr_ready,
    output logic [1:0]               wr_mat,
    output logic [PE_N-1:0]          wr_row,
    output logic [PG_W-1:0]          wr_page,
    output logic [PE_N-1:0]          wr_cell_en,
    output logic [PE_N*CELL_W-1:0]   wr_data
);

    if (BUS_W != PE_N * CELL_W) begin : g_bad_bus_w
        $error("axi_tile_unpacker: BUS_W must equal PE_N*CELL_W");
    end
    if ((MAX_BEATS & (MAX_BEATS - 1)) != 0 || MAX_BEATS < PE_N) begin : g_bad_max_beats
        $error("axi_tile_unpacker: MAX_BEATS must be a power of 2 and >= PE_N");
    end

    localparam int ROW_W = $clog2(PE_N);
    localparam int EW16  = CELL_W / 2;
    localparam int EW8   = CELL_W / 4;
    localparam int EW4   = CELL_W / 8;

    localparam logic [1:0] MAT_C    = 2'd2;
    localparam logic [1:0] MAT_BAD  = 2'd3;
    localparam logic [1:0] TY_FP32  = 2'd0;
    localparam logic [1:0] TY_FP16  = 2'd1;
    localparam logic [1:0] TY_INT8  = 2'd2;

    typedef enum logic [1:0] {S_IDLE, S_RECV, S_FLUSH, S_DONE} state_t;

    state_t                  state_q, state_d;
    logic [LEN_W-1:0]        k_q, k_d;
    logic [LEN_W-1:0]        len_q, len_d;
    logic [1:0]              mat_q, mat_d;
    logic [1:0]              typ_q, typ_d;
    logic                    err_q, err_d;
    logic                    wr_valid_q, wr_valid_d;
    logic [PE_N-1:0]         wr_row_q, wr_row_d;
    logic [PG_W-1:0]         wr_page_q, wr_page_d;
    logic [BUS_W-1:0]        wr_data_q, wr_data_d;

    logic                    accept;
    logic                    cfg_bad;
    logic [BUS_W-1:0]        cell_data;

    // State register (FSM state plus the datapath flops it steers).
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            k_q        <= '0;
            len_q      <= '0;
            mat_q      <= '0;
            typ_q      <= '0;
            err_q      <= 1'b0;
            wr_valid_q <= 1'b0;
            wr_row_q   <= '0;
            wr_page_q  <= '0;
            wr_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            k_q        <= k_d;
            len_q      <= len_d;
            mat_q      <= mat_d;
            typ_q      <= typ_d;
            err_q      <= err_d;
            wr_valid_q <= wr_valid_d;
            wr_row_q   <= wr_row_d;
            wr_page_q  <= wr_page_d;
            wr_data_q  <= wr_data_d;
        end
    end

    // Output decode.
    always_comb begin
        busy    = (state_q != S_IDLE);
        done    = (state_q == S_DONE);
        // A beat may enter only if the output register is empty or draining now.
        s_ready = (state_q == S_RECV) && (!wr_valid_q || wr_ready);
    end

    assign accept  = s_valid && s_ready;
    assign cfg_bad = (cfg_len == '0) || (cfg_len > LEN_W'(MAX_BEATS)) || (cfg_mat == MAT_BAD);

    // Next-state and control.
    always_comb begin
        // NOTE: every variable gets a hold default up front so no path can infer a latch.
        state_d = state_q;
        k_d     = k_q;
        len_d   = len_q;
        mat_d   = mat_q;
        typ_d   = typ_q;
        err_d   = err_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    mat_d   = cfg_mat;
                    typ_d   = cfg_type;
                    len_d   = cfg_len;
                    k_d     = '0;
                    err_d   = cfg_bad;
                    state_d = cfg_bad ? S_DONE : S_RECV;
                end
            end
            S_RECV: begin
                if (accept) begin
                    k_d = k_q + LEN_W'(1);
                    if (k_q == len_q - LEN_W'(1)) begin
                        state_d = S_FLUSH;
                        if (!s_last) err_d = 1'b1;
                    end else if (s_last) begin
                        // Early LAST: stop taking beats, finish what is in flight.
                        state_d = S_FLUSH;
                        err_d   = 1'b1;
                    end
                end
            end
            S_FLUSH: begin
                if (!wr_valid_q || wr_ready) state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // C-bank widening: element i sits at s_data[ew*i +: ew].
    always_comb begin
        cell_data = s_data;
        if (mat_q == MAT_C) begin
            for (int i = 0; i < PE_N; i++) begin
                unique case (typ_q)
                    TY_FP32: cell_data[CELL_W*i +: CELL_W] = s_data[CELL_W*i +: CELL_W];
                    TY_FP16: cell_data[CELL_W*i +: CELL_W] = CELL_W'(s_data[EW16*i +: EW16]);
                    TY_INT8: cell_data[CELL_W*i +: CELL_W] = CELL_W'($signed(s_data[EW8*i +: EW8]));
                    default: cell_data[CELL_W*i +: CELL_W] = CELL_W'($signed(s_data[EW4*i +: EW4]));
                endcase
            end
        end
    end

    // Single output register: load on accept (which may coincide with a drain),
    // clear on a drain with nothing new, otherwise hold.
    always_comb begin
        wr_valid_d = wr_valid_q;
        wr_row_d   = wr_row_q;
        wr_page_d  = wr_page_q;
        wr_data_d  = wr_data_q;
        if (accept) begin
            wr_valid_d = 1'b1;
            wr_row_d   = {{(PE_N-1){1'b0}}, 1'b1} << k_q[ROW_W-1:0];
            wr_page_d  = k_q[ROW_W +: PG_W];
            wr_data_d  = cell_data;
        end else if (wr_valid_q && wr_ready) begin
            wr_valid_d = 1'b0;
        end
    end

    assign err        = err_q;
    assign wr_valid   = wr_valid_q;
    assign wr_mat     = mat_q;
    assign wr_row     = wr_row_q;
    assign wr_page    = wr_page_q;
    assign wr_data    = wr_data_q;
    assign wr_cell_en = {PE_N{wr_valid_q}};

endmodule
